// File: rtl/usb_mode_switch_if.sv
// Mode-switch control signals shared between the switch controller and the
// USB streaming / reset-bridge side.
interface usb_mode_switch_if;
  logic mode_req;
  logic drain_ack;
  logic usb_reset_n;
  logic usb_working_mode;
  logic drain_req;
  logic switch_busy;
  logic switch_done;
  logic timeout_err;

  // Controller side
  modport master (
    input  mode_req,
    input  drain_ack,
    input  usb_reset_n,
    output usb_working_mode,
    output drain_req,
    output switch_busy,
    output switch_done,
    output timeout_err
  );

  // Environment side: request source, streaming logic and reset bridge
  modport slave (
    output mode_req,
    output drain_ack,
    output usb_reset_n,
    input  usb_working_mode,
    input  drain_req,
    input  switch_busy,
    input  switch_done,
    input  timeout_err
  );
endinterface

// File: rtl/usb_mode_switch_ctrl.sv
// CDC/UVC working-mode switch controller: debounce, drain handshake, reset tracking, holdoff.
// Optional drain-wait timeout (forced switch) enabled by macro USB_MODE_DRAIN_TIMEOUT_EN.
module usb_mode_switch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DRAIN_TIMEOUT   = 1024,
  parameter int unsigned HOLDOFF_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  usb_mode_switch_if.master  ms_if
);

  localparam int unsigned MAX_DH = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES
                                                                       : HOLDOFF_CYCLES;
  localparam int unsigned MAX_P  = (MAX_DH > DRAIN_TIMEOUT) ? MAX_DH : DRAIN_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_DRAIN,
    ST_WAIT_RST_LOW,
    ST_WAIT_RST_HIGH,
    ST_HOLDOFF
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync2_q;
  logic               mode_q, mode_d;
  logic               drain_req_q, drain_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
  logic               tmo_q, tmo_d;
`endif

  logic mode_sync;
  assign mode_sync = sync2_q;

  // State, counter, synchronizer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      mode_q      <= 1'b0;
      drain_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= ms_if.mode_req;
      sync2_q     <= sync1_q;
      mode_q      <= mode_d;
      drain_req_q <= drain_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next-state logic; the shared counter defaults to zero so any transition clears it
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    mode_d  = mode_q;
    done_d  = 1'b0;
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (mode_sync != mode_q) begin
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (mode_sync == mode_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Switch is committed here; later mode_req changes wait until IDLE
      ST_DRAIN: begin
        if (ms_if.drain_ack) begin
          mode_d  = ~mode_q;
          state_d = ST_WAIT_RST_LOW;
        end
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          mode_d  = ~mode_q;
          state_d = ST_WAIT_RST_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_WAIT_RST_LOW: begin
        if (!ms_if.usb_reset_n) begin
          state_d = ST_WAIT_RST_HIGH;
        end
      end

      ST_WAIT_RST_HIGH: begin
        if (ms_if.usb_reset_n) begin
          state_d = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    drain_req_d = (state_d == ST_DRAIN) || (state_d == ST_WAIT_RST_LOW) ||
                  (state_d == ST_WAIT_RST_HIGH);
    busy_d      = drain_req_d || (state_d == ST_HOLDOFF);
  end

  assign ms_if.usb_working_mode = mode_q;
  assign ms_if.drain_req        = drain_req_q;
  assign ms_if.switch_busy      = busy_q;
  assign ms_if.switch_done      = done_q;
`ifdef USB_MODE_DRAIN_TIMEOUT_EN
  assign ms_if.timeout_err      = tmo_q;
`else
  assign ms_if.timeout_err      = 1'b0;
`endif

endmodule
